// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - registered ShiftRows/InvShiftRows stage with a 2-entry elastic buffer
//
// Rotates the four rows of an NB-column AES/Rijndael state. The direction is
// chosen per beat. The result is registered together with its tag and mode.
// A skid register lets the stage accept a beat in the same cycle the
// downstream stalls, so o_ready depends only on registered occupancy.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_valid/o_ready   upstream handshake
//   i_inverse         0 = ShiftRows, 1 = InvShiftRows for the offered beat
//   i_tag             sideband tag, carried through unchanged
//   i_data            state, row-major, byte 0 of each row in the MSBs
//   o_valid/i_ready   downstream handshake
//   o_data/o_tag/o_inverse  transformed state, its tag and its mode
//   o_beats           completed output transfers, wraps at 2^CNT_W

module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_inverse,
    input  logic [TAG_W-1:0]    i_tag,
    input  logic [32*NB-1:0]    i_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [32*NB-1:0]    o_data,
    output logic [TAG_W-1:0]    o_tag,
    output logic                o_inverse,
    output logic [CNT_W-1:0]    o_beats
);

    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                in_fire;
    logic                out_fire;
    logic                load_out;
    logic                load_skid;
    logic                skid_to_out;
    logic [W-1:0]        xf_data;
    logic [W-1:0]        skid_data;
    logic [TAG_W-1:0]    skid_tag;
    logic                skid_inverse;

    // Byte permutation. All indices are elaboration constants, so this is
    // pure wiring plus one 2:1 mux per byte for the direction.
    for (genvar r = 0; r < 4; r++) begin : g_row
        // Rijndael offsets: 0,1,2,3, except that the wide block uses 0,1,3,4.
        localparam int SH = (NB == 8 && r >= 2) ? r + 1 : r;
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int FWD = (c + SH) % NB;
            localparam int INV = (c + NB - SH) % NB;
            localparam int TOP = W - 1 - 8 * NB * r;
            assign xf_data[TOP - 8*c -: 8] = i_inverse ? i_data[TOP - 8*INV -: 8]
                                                       : i_data[TOP - 8*FWD -: 8];
        end
    end

    assign o_valid  = (state != EMPTY);
    assign o_ready  = (state != TWO) & ~rst;
    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt = ONE;
                    load_out  = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_out = 1'b1;
                end else if (in_fire) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                // o_ready is low here, so no new beat can arrive this cycle.
                if (out_fire) begin
                    state_nxt   = ONE;
                    skid_to_out = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data       <= '0;
            o_tag        <= '0;
            o_inverse    <= 1'b0;
            skid_data    <= '0;
            skid_tag     <= '0;
            skid_inverse <= 1'b0;
            o_beats      <= '0;
        end else begin
            if (load_out) begin
                o_data    <= xf_data;
                o_tag     <= i_tag;
                o_inverse <= i_inverse;
            end else if (skid_to_out) begin
                o_data    <= skid_data;
                o_tag     <= skid_tag;
                o_inverse <= skid_inverse;
            end
            if (load_skid) begin
                skid_data    <= xf_data;
                skid_tag     <= i_tag;
                skid_inverse <= i_inverse;
            end
            if (out_fire) begin
                o_beats <= o_beats + CNT_W'(1);
            end
        end
    end

endmodule
